// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing helpers and arbiter state encoding
package uart_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic int bit_cyc(int clk_freq, int baud);
    return clk_freq / baud;
  endfunction
  function automatic int frame_cyc(int clk_freq, int baud, int dlen, int guard);
    return bit_cyc(clk_freq, baud) * (dlen + 2 + guard);
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit at or above ptr with wrap
module rr_pick #(
  parameter int N = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  oh,
  output logic [PW-1:0] win,
  output logic          any
);
  int idx;
  always_comb begin
    oh = '0;
    win = '0;
    any = |req;
    idx = 0;
    // Scan farthest offset first so the nearest requester above ptr wins last
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        oh = '0;
        oh[idx] = 1'b1;
        win = PW'(idx);
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among N_REQ byte producers,
// timing each frame itself since uart_tx exposes no busy flag
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int Baud_Rate = 115200,
  parameter int Clk_Freq = 50_000_000,
  parameter int DATA_LEN = 8,
  parameter int GUARD_BITS = 1
) (
  input  logic                      clk_sys,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_LEN-1:0] req_dat,
  output logic [N_REQ-1:0]          gnt,
  output logic [DATA_LEN-1:0]       tx_dat,
  output logic                      tx_en,
  output logic                      busy
);
  localparam int FRAME_CYC = frame_cyc(Clk_Freq, Baud_Rate, DATA_LEN, GUARD_BITS);
  localparam int CW = $clog2(FRAME_CYC + 1);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  state_t state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr, win;
  logic [N_REQ-1:0] oh;
  logic any;
  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req(req),
    .ptr(ptr),
    .oh (oh),
    .win(win),
    .any(any)
  );
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      tx_en <= 1'b0;
      tx_dat <= '0;
      busy <= 1'b0;
      cnt <= '0;
      ptr <= '0;
    end else begin
      gnt <= '0;
      tx_en <= 1'b0;
      if (state == IDLE) begin
        if (any) begin
          gnt <= oh;
          tx_en <= 1'b1;
          tx_dat <= req_dat[int'(win)*DATA_LEN +: DATA_LEN];
          busy <= 1'b1;
          cnt <= CW'(FRAME_CYC - 1);
          ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
          state <= SEND;
        end
      end else if (cnt == '0) begin
        state <= IDLE;
        busy <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, frame timing, reset and N_REQ=1 corner
module tb_uart_tx_arbiter;
  logic clk_sys = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [31:0] req_dat = '0;
  logic [3:0] gnt;
  logic [7:0] tx_dat;
  logic tx_en, busy;
  logic req1 = 1'b0;
  logic [7:0] req1_dat = 8'h5c;
  logic gnt1;
  logic [7:0] tx_dat1;
  logic tx_en1, busy1;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int q_t[$];
  logic [7:0] q_d[$];
  logic [3:0] q_g[$];
  int q1[$];

  uart_tx_arbiter u_dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .req(req), .req_dat(req_dat),
    .gnt(gnt), .tx_dat(tx_dat), .tx_en(tx_en), .busy(busy)
  );

  uart_tx_arbiter #(.N_REQ(1), .Baud_Rate(12_500_000), .GUARD_BITS(0)) u_one (
    .clk_sys(clk_sys), .rst_n(rst_n), .req(req1), .req_dat(req1_dat),
    .gnt(gnt1), .tx_dat(tx_dat1), .tx_en(tx_en1), .busy(busy1)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (gnt != '0) begin
      check("gnt_onehot", 32'($onehot(gnt)), 1);
      check("gnt_with_en", 32'(tx_en), 1);
    end
    if (tx_en) begin
      q_t.push_back(cyc);
      q_d.push_back(tx_dat);
      q_g.push_back(gnt);
    end
    if (tx_en1) q1.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_q();
    q_t.delete();
    q_d.delete();
    q_g.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req = '0;
    clear_q();
  endtask

  task automatic run_ev(input int n, input int budget, input bit hold);
    int k = 0;
    while (q_t.size() < n && k < budget) begin
      tick();
      if (!hold) req = req & ~gnt;
      k++;
    end
    check("ev_count", q_t.size(), n);
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("rst_gnt", gnt, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_dat", tx_dat, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    req1 = 1'b1;
    tick();
    // single request and frame length
    req_dat = 32'h00a5_0000;
    req = 4'b0100;
    tick();
    req = '0;
    check("single_gnt", gnt, 4'b0100);
    check("single_en", tx_en, 1);
    check("single_dat", tx_dat, 8'ha5);
    check("single_busy", busy, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 6000);
    check("single_busy_len", n, 4774);
    // simultaneous requests from ptr=0
    do_reset();
    req_dat = 32'h2300_2100;
    req = 4'b1010;
    run_ev(2, 12000, 1'b0);
    if (q_t.size() >= 2) begin
      check("simul_g0", q_g[0], 4'b0010);
      check("simul_d0", q_d[0], 8'h21);
      check("simul_g1", q_g[1], 4'b1000);
      check("simul_d1", q_d[1], 8'h23);
      check("simul_gap", q_t[1] - q_t[0], 4775);
    end
    // fairness with all requesters held
    do_reset();
    req_dat = 32'h1312_1110;
    req = 4'b1111;
    run_ev(5, 25000, 1'b1);
    req = '0;
    if (q_t.size() >= 5) begin
      check("fair_d0", q_d[0], 8'h10);
      check("fair_d1", q_d[1], 8'h11);
      check("fair_d2", q_d[2], 8'h12);
      check("fair_d3", q_d[3], 8'h13);
      check("fair_d4", q_d[4], 8'h10);
      for (int i = 1; i < 5; i++) check("fair_gap", q_t[i] - q_t[i-1], 4775);
    end
    // request pulsed during SEND is ignored
    do_reset();
    req_dat = 32'h0000_0077;
    req = 4'b0001;
    run_ev(1, 10, 1'b0);
    repeat (100) tick();
    req = 4'b0001;
    tick();
    req = '0;
    n = 0;
    while (busy && n < 6000) begin
      tick();
      n++;
    end
    repeat (20) tick();
    check("ignore_busy", busy, 0);
    check("ignore_count", q_t.size(), 1);
    // reset mid-frame
    do_reset();
    req_dat = 32'h9900_0042;
    req = 4'b0100;
    run_ev(1, 10, 1'b0);
    repeat (2773) tick();
    check("midrst_busy_pre", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_dat", tx_dat, 0);
    check("midrst_en", tx_en, 0);
    req = 4'b1000;
    tick();
    req = '0;
    check("midrst_gnt", gnt, 4'b1000);
    check("midrst_tx_en", tx_en, 1);
    check("midrst_tx_dat", tx_dat, 8'h99);
    // N_REQ=1 rate limiter with FRAME_CYC=40
    q1.delete();
    repeat (130) tick();
    check("one_count", 32'(q1.size() >= 3), 1);
    if (q1.size() >= 3) begin
      check("one_gap0", q1[1] - q1[0], 41);
      check("one_gap1", q1[2] - q1[1], 41);
    end
    check("one_dat", tx_dat1, 8'h5c);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serializer between N_REQ byte producers, e.g. the rx echo path, a status reporter and a debug dumper. Arbitrates round-robin and drives the serializer's tx_dat and one-cycle tx_en. uart_tx has no busy output, so the arbiter times each frame with its own counter and holds off the next grant until the line is free. Sits in the top level between the producers and the uart_tx instance, all on clk_sys.

Parameters:
N_REQ, 4, number of requesters (1..8)
Baud_Rate, 115200, serial bit rate
Clk_Freq, 50_000_000, clk_sys frequency in Hz
DATA_LEN, 8, data bits per frame
GUARD_BITS, 1, idle bit-times inserted after each frame's stop bit

Ports:
clk_sys  in  1  system clock; all logic on rising edge
rst_n  in  1  reset; synchronous, active-low
req  in  N_REQ  per-requester request; held high with req_dat stable until granted
req_dat  in  N_REQ*DATA_LEN  requester i byte at [i*DATA_LEN +: DATA_LEN]
gnt  out  N_REQ  one-hot one-cycle pulse: requester's byte accepted
tx_dat  out  DATA_LEN  byte to uart_tx; held until the next grant
tx_en  out  1  one-cycle start pulse to uart_tx
busy  out  1  high while a frame or guard time is in progress

Behaviour:
- Derived constants:
  - BIT_CYC = Clk_Freq/Baud_Rate, integer divide (434 at defaults).
  - FRAME_CYC = BIT_CYC*(DATA_LEN+2+GUARD_BITS) (4774 at defaults).
  - Counter width = $clog2(FRAME_CYC+1).
- Reset (rst_n low at a clock edge): state=IDLE, gnt=0, tx_en=0, tx_dat=0, busy=0, counter=0, ptr=0. Reset overrides everything, including mid-frame; any frame in flight is abandoned with no further gnt.
- States: IDLE and SEND.
- IDLE:
  - req is sampled every cycle.
  - If any bit is set, the winner w is the first set bit searching upward from ptr, wrapping at N_REQ.
  - At the next edge: gnt[w]=1, tx_en=1, tx_dat=req_dat slice w, busy=1, counter=FRAME_CYC-1, ptr=(w+1) mod N_REQ, state=SEND.
  - If req==0, stay in IDLE; outputs unchanged except gnt=0 and tx_en=0.
- SEND:
  - gnt and tx_en are forced to 0 after their single cycle.
  - The counter decrements each cycle. When it reaches 0, the next edge sets state=IDLE and busy=0.
  - req is ignored in SEND.
- Timing:
  - Latency from req high in IDLE to gnt/tx_en is 1 cycle.
  - Minimum spacing between successive tx_en pulses is FRAME_CYC+1 cycles: FRAME_CYC in SEND plus one arbitration cycle.
- Requester rules:
  - A requester with more bytes keeps req high and updates req_dat in the cycle after its gnt.
  - A requester that is done drops req by then; req sampled in SEND has no effect.
  - A req withdrawn before gnt is simply not served; no error.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,N_REQ-1,0,... No requester waits more than N_REQ-1 other frames.
- N_REQ=1: the arbiter degenerates to a rate limiter with the same timing.
- Invariants: gnt is one-hot or zero, and is asserted only together with tx_en.

Decomposition:
- Package uart_pkg holds:
  - the BIT_CYC and FRAME_CYC computation functions (shared with uart_rx and uart_tx);
  - the state enum {IDLE, SEND}.
- One sub-module, rr_pick: combinational round-robin picker. Inputs: req vector and ptr. Outputs: one-hot grant vector, winner index and an any flag.
- The counter, FSM and data mux live in uart_tx_arbiter.

Test Plan:
- Single request: rst_n released, req=4'b0100 with slice2=8'hA5 for one cycle in IDLE -> next cycle gnt=4'b0100, tx_en=1, tx_dat=8'hA5, busy=1; busy falls exactly 4774 cycles later.
- Simultaneous requests: req=4'b1010 from reset (ptr=0) -> first grant to 1 (tx_dat=slice1), second grant to 3 exactly 4775 cycles after the first tx_en.
- Fairness: req=4'b1111 held continuously with distinct bytes 8'h10..8'h13 -> tx_dat sequence 10,11,12,13,10, with tx_en spacing always 4775 cycles.
- Ignore during SEND: req=4'b0001 pulsed for 1 cycle mid-SEND, then dropped -> no extra gnt/tx_en; arbiter returns to IDLE and stays there.
- Reset mid-frame: rst_n low 1 cycle at counter=2000 -> next cycle busy=0, tx_dat=0, state IDLE, ptr=0; a subsequent req=4'b1000 is granted 1 cycle later.
- Parameter corner: N_REQ=1, Baud_Rate=Clk_Freq/4, GUARD_BITS=0 -> FRAME_CYC=40; with req held high, tx_en pulses every 41 cycles.
